// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter
//   Round-robin, packet-locked arbiter that merges INPUT_NUMBER valid/ready/last
//   streams onto one output stream. A grant is picked in IDLE, then held in
//   LOCKED until the granted requester completes a beat with last set. Every
//   packet is therefore preceded by exactly one arbitration cycle.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  per-requester valid
//   req_last_i   per-requester end-of-packet flag
//   req_data_i   per-requester data words (unpacked array)
//   req_ready_o  per-requester ready (only the granted bit can be high)
//   m_valid_o    output stream valid
//   m_last_o     output stream last
//   m_data_o     output stream data (zero when not locked)
//   m_ready_i    downstream ready
//   grant_o      registered grant index
//   busy_o       high while LOCKED
//
// state  | meaning
// IDLE   | no packet in flight; arbitrate among valid requesters
// LOCKED | grant held; output stream follows requester grant_o

module rr_stream_arbiter #(
   parameter  int DATA_WIDTH   = 8,
   parameter  int INPUT_NUMBER = 8,
   localparam int SEL_W        = $clog2(INPUT_NUMBER)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [INPUT_NUMBER-1:0] req_valid_i,
   input  logic [INPUT_NUMBER-1:0] req_last_i,
   input  logic [DATA_WIDTH-1:0]   req_data_i [INPUT_NUMBER],
   output logic [INPUT_NUMBER-1:0] req_ready_o,
   output logic                    m_valid_o,
   output logic                    m_last_o,
   output logic [DATA_WIDTH-1:0]   m_data_o,
   input  logic                    m_ready_i,
   output logic [SEL_W-1:0]        grant_o,
   output logic                    busy_o
);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   state_t             r_state;
   logic [SEL_W-1:0]   r_grant;
   logic [SEL_W-1:0]   r_ptr;
   logic               r_busy;

   logic               w_locked;
   logic               w_any;
   logic               w_hi_found;
   logic [SEL_W-1:0]   w_hi;
   logic [SEL_W-1:0]   w_lo;
   logic [SEL_W-1:0]   w_pick;
   logic               w_end_of_pkt;

   // Round-robin pick: lowest set bit at or above the pointer; if none, wrap
   // to the lowest set bit overall. The descending scan leaves the lowest
   // qualifying index in each candidate.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi       = '0;
      w_lo       = '0;
      for (int i = INPUT_NUMBER - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            w_lo = SEL_W'(i);
            if (SEL_W'(i) >= r_ptr) begin
               w_hi_found = 1'b1;
               w_hi       = SEL_W'(i);
            end
         end
      end
      w_pick = w_hi_found ? w_hi : w_lo;
   end

   assign w_any    = |req_valid_i;
   assign w_locked = (r_state == ST_LOCKED);

   // Datapath is combinational from the registered grant, gated by LOCKED so
   // that reset and IDLE force every output to zero.
   assign m_valid_o = w_locked & req_valid_i[r_grant];
   assign m_last_o  = w_locked & req_last_i[r_grant];
   assign m_data_o  = w_locked ? req_data_i[r_grant] : '0;

   always_comb begin
      req_ready_o = '0;
      if (w_locked) begin
         req_ready_o[r_grant] = m_ready_i;
      end
   end

   assign w_end_of_pkt = m_valid_o & m_ready_i & m_last_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_state <= ST_LOCKED;
                  r_busy  <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (w_end_of_pkt) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_ptr   <= (r_grant == SEL_W'(INPUT_NUMBER - 1)) ? '0 : r_grant + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant_o = r_grant;
   assign busy_o  = r_busy;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (8 requesters, 8-bit data).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge (or immediately after an asynchronous reset assertion).

module tb_rr_stream_arbiter;

   localparam int DW = 8;
   localparam int N  = 8;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_last;
   logic [DW-1:0] req_data [N];
   logic [N-1:0]  req_ready;
   logic          m_valid;
   logic          m_last;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [2:0]    grant;
   logic          busy;

   int n_chk;
   int n_err;
   int xfers;
   int x0;

   rr_stream_arbiter #(.DATA_WIDTH(DW), .INPUT_NUMBER(N)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_last_i  (req_last),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .m_valid_o   (m_valid),
      .m_last_o    (m_last),
      .m_data_o    (m_data),
      .m_ready_i   (m_ready),
      .grant_o     (grant),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are stable from posedge+1 to the next posedge, so the falling
   // edge sees exactly what the next rising edge will sample.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) xfers++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      xfers = 0;
      rst       = 1'b0;
      req_valid = '0;
      req_last  = '0;
      m_ready   = 1'b1;
      for (int i = 0; i < N; i++) req_data[i] = '0;

      // ---- reset with a request pending: outputs must stay zero
      #1;
      rst         = 1'b1;
      req_valid   = 8'h04;
      req_data[2] = 8'h5A;
      #1;
      chk("rst_valid", 32'(m_valid), 32'h0);
      chk("rst_data",  32'(m_data),  32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy",  32'(busy),  32'h0);
      nxt;
      nxt;
      rst       = 1'b0;
      req_valid = '0;
      mid;
      chk("idle_busy", 32'(busy), 32'h0);

      // ---- single requester 2, three beats
      nxt;
      x0          = xfers;
      req_valid   = 8'h04;
      req_last    = 8'h00;
      req_data[2] = 8'hA1;
      mid;
      chk("a_arb_valid", 32'(m_valid), 32'h0);
      chk("a_arb_data",  32'(m_data),  32'h0);
      nxt;
      mid;
      chk("a_grant", 32'(grant), 32'h2);
      chk("a_busy",  32'(busy),  32'h1);
      chk("a_d1",    32'(m_data), 32'hA1);
      chk("a_ready", 32'(req_ready), 32'h04);
      nxt;
      req_data[2] = 8'hA2;
      mid;
      chk("a_d2", 32'(m_data), 32'hA2);
      nxt;
      req_data[2] = 8'hA3;
      req_last    = 8'h04;
      mid;
      chk("a_d3",   32'(m_data), 32'hA3);
      chk("a_last", 32'(m_last), 32'h1);
      nxt;
      req_valid = '0;
      req_last  = '0;
      mid;
      chk("a_done_busy", 32'(busy), 32'h0);
      chk("a_xfers", 32'(xfers - x0), 32'd3);

      // ---- async reset while locked on grant 3 (pointer is 3)
      nxt;
      req_valid   = 8'h08;
      req_data[3] = 8'h33;
      mid;
      nxt;
      mid;
      chk("r_grant3", 32'(grant), 32'h3);
      chk("r_busy1",  32'(busy),  32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("r_busy0",  32'(busy),  32'h0);
      chk("r_valid0", 32'(m_valid), 32'h0);
      chk("r_ready0", 32'(req_ready), 32'h0);
      chk("r_grant0", 32'(grant), 32'h0);
      nxt;
      req_valid = '0;
      nxt;
      rst = 1'b0;
      mid;
      chk("r_post_valid", 32'(m_valid), 32'h0);
      nxt;
      mid;
      chk("r_post_busy", 32'(busy), 32'h0);

      // ---- round robin: everyone sends 1-beat packets, data = index
      nxt;
      for (int i = 0; i < N; i++) req_data[i] = DW'(i);
      req_valid = 8'hFF;
      req_last  = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         mid;
         chk("rr_gap", 32'(m_valid), 32'h0);
         nxt;
         mid;
         chk("rr_valid", 32'(m_valid), 32'h1);
         chk("rr_data",  32'(m_data), 32'(k % N));
         nxt;
      end
      req_valid = '0;
      req_last  = '0;

      // ---- pointer wrap: grant 6 (pointer now 2), then requests on 1 and 7
      req_valid   = 8'h40;
      req_last    = 8'h40;
      req_data[6] = 8'h66;
      nxt;
      mid;
      chk("w_grant6", 32'(grant), 32'h6);
      nxt;
      req_valid   = 8'h82;
      req_last    = 8'h82;
      req_data[1] = 8'h11;
      req_data[7] = 8'h77;
      mid;
      chk("w_gap1", 32'(busy), 32'h0);
      nxt;
      mid;
      chk("w_grant7", 32'(grant), 32'h7);
      chk("w_data7",  32'(m_data), 32'h77);
      nxt;
      mid;
      chk("w_gap2", 32'(m_valid), 32'h0);
      nxt;
      mid;
      chk("w_grant1", 32'(grant), 32'h1);
      chk("w_data1",  32'(m_data), 32'h11);
      nxt;
      req_valid = '0;
      req_last  = '0;

      // ---- backpressure on requester 5: ready 1,0,0,1 over a 2-beat packet
      x0          = xfers;
      req_valid   = 8'h20;
      req_data[5] = 8'hB1;
      m_ready     = 1'b1;
      nxt;
      mid;
      chk("b_grant", 32'(grant), 32'h5);
      chk("b_rdy1",  32'(req_ready), 32'h20);
      chk("b_d1",    32'(m_data), 32'hB1);
      nxt;
      req_data[5] = 8'hB2;
      req_last    = 8'h20;
      m_ready     = 1'b0;
      mid;
      chk("b_rdy2", 32'(req_ready), 32'h00);
      chk("b_d2a",  32'(m_data), 32'hB2);
      chk("b_last", 32'(m_last), 32'h1);
      nxt;
      mid;
      chk("b_d2b",   32'(m_data), 32'hB2);
      chk("b_grant_hold", 32'(grant), 32'h5);
      nxt;
      m_ready = 1'b1;
      mid;
      chk("b_rdy4", 32'(req_ready), 32'h20);
      chk("b_d2c",  32'(m_data), 32'hB2);
      nxt;
      req_valid = '0;
      req_last  = '0;
      mid;
      chk("b_done", 32'(busy), 32'h0);
      chk("b_xfers", 32'(xfers - x0), 32'd2);

      // ---- lock hold: requester 4 stalls 3 cycles while requester 0 waits
      nxt;
      req_valid   = 8'h10;
      req_data[4] = 8'hC1;
      nxt;
      mid;
      chk("l_grant4", 32'(grant), 32'h4);
      chk("l_d1",     32'(m_data), 32'hC1);
      nxt;
      req_valid   = 8'h01;
      req_data[0] = 8'hD0;
      req_last    = 8'h01;
      for (int k = 0; k < 3; k++) begin
         mid;
         chk("l_hold_grant", 32'(grant), 32'h4);
         chk("l_hold_valid", 32'(m_valid), 32'h0);
         chk("l_hold_ready", 32'(req_ready), 32'h10);
         nxt;
      end
      req_valid   = 8'h11;
      req_last    = 8'h11;
      req_data[4] = 8'hC2;
      mid;
      chk("l_d2",    32'(m_data), 32'hC2);
      chk("l_last4", 32'(m_last), 32'h1);
      nxt;
      mid;
      chk("l_gap", 32'(m_valid), 32'h0);
      nxt;
      mid;
      chk("l_grant0", 32'(grant), 32'h0);
      chk("l_d0",     32'(m_data), 32'hD0);
      nxt;
      req_valid = '0;
      req_last  = '0;
      mid;
      chk("l_done", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
